// File: rtl/cart_to_polar.sv
`default_nettype none
// ============================================================================
// Module      : cart_to_polar
// Description : Post-FFT reader. Streams the real/imaginary FFT buffers bin
//               by bin, writes each bin's squared magnitude to the magnitude
//               buffer, tracks the strongest bin and pulses go_out at the end
//               of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_to_polar #(
    parameter int N_BINS = 2048,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go_in,
    output logic [ADDR_W-1:0] real_buf_addr,
    input  logic [15:0]       real_buf_data,
    output logic [ADDR_W-1:0] imag_buf_addr,
    input  logic [15:0]       imag_buf_data,
    output logic [ADDR_W-1:0] mag_buf_addr,
    output logic [31:0]       mag_buf_data,
    output logic              mag_buf_wren,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [31:0]       peak_mag,
    output logic              busy,
    output logic              go_out
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(N_BINS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // Reset: asserts asynchronously, releases synchronously to clk
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Two-flop release synchronizer for the external reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              r_v1;       // buffer data valid this cycle
    logic [ADDR_W-1:0] r_a1;
    logic              r_v2;       // squares valid this cycle
    logic [ADDR_W-1:0] r_a2;
    logic [31:0]       r_re_sq;    // bit 31 is always 0 (max 2^30)
    logic [31:0]       r_im_sq;
    logic              r_wren;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_mag;

    logic [ADDR_W-1:0] r_wk_bin;
    logic [31:0]       r_wk_mag;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [31:0]       r_peak_mag;

    logic              w_start;
    logic              w_issue;
    logic              w_last_addr;
    logic              w_last_write;
    logic              w_take;
    logic [ADDR_W-1:0] w_wk_bin_nxt;
    logic [31:0]       w_wk_mag_nxt;
    logic signed [31:0] w_re_ext;
    logic signed [31:0] w_im_ext;
    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;

    assign w_start      = (r_state == c_ST_IDLE) && go_in;
    assign w_issue      = (r_state == c_ST_READ);
    assign w_last_addr  = (r_rd_addr == c_LAST_ADDR);
    assign w_last_write = r_wren && (r_wr_addr == c_LAST_ADDR);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        go_out      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (go_in) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                busy = 1'b1;
                if (w_last_addr) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                busy = 1'b1;
                if (w_last_write) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                go_out      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read address generation
    // ------------------------------------------------------------------------
    // Counts 0..N_BINS-1 while reading, otherwise parked at 0
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_addr <= '0;
        end else if (w_issue && !w_last_addr) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end else begin
            r_rd_addr <= '0;
        end
    end

    assign real_buf_addr = r_rd_addr;
    assign imag_buf_addr = r_rd_addr;

    // ------------------------------------------------------------------------
    // Datapath. The buffers' own output register acts as the capture stage,
    // so the squares are formed straight from the returned data.
    // ------------------------------------------------------------------------
    assign w_re_ext = {{16{real_buf_data[15]}}, real_buf_data};
    assign w_im_ext = {{16{imag_buf_data[15]}}, imag_buf_data};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Valid/address alignment with the buffer read latency
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v1 <= 1'b0;
            r_a1 <= '0;
            r_v2 <= 1'b0;
            r_a2 <= '0;
        end else begin
            r_v1 <= w_issue;
            r_a1 <= r_rd_addr;
            r_v2 <= r_v1;
            r_a2 <= r_a1;
        end
    end

    // Square register stage
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_re_sq <= '0;
            r_im_sq <= '0;
        end else if (r_v1) begin
            r_re_sq <= w_re_sq;
            r_im_sq <= w_im_sq;
        end
    end

    // Sum register stage, drives the magnitude buffer write port
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wren    <= 1'b0;
            r_wr_addr <= '0;
            r_mag     <= '0;
        end else begin
            r_wren <= r_v2;
            if (r_v2) begin
                r_wr_addr <= r_a2;
                r_mag     <= r_re_sq + r_im_sq;  // max 2^31, cannot wrap
            end
        end
    end

    assign mag_buf_wren = r_wren;
    assign mag_buf_addr = r_wr_addr;
    assign mag_buf_data = r_mag;

    // ------------------------------------------------------------------------
    // Peak tracking: strict compare keeps the lowest bin on ties
    // ------------------------------------------------------------------------
    assign w_take       = r_wren && (r_mag > r_wk_mag);
    assign w_wk_bin_nxt = w_take ? r_wr_addr : r_wk_bin;
    assign w_wk_mag_nxt = w_take ? r_mag     : r_wk_mag;

    // Working peak, cleared when a frame is accepted
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wk_bin <= '0;
            r_wk_mag <= '0;
        end else if (w_start) begin
            r_wk_bin <= '0;
            r_wk_mag <= '0;
        end else if (r_wren) begin
            r_wk_bin <= w_wk_bin_nxt;
            r_wk_mag <= w_wk_mag_nxt;
        end
    end

    // Published peak, loaded with the last write folded in so it is valid in DONE
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else if (w_last_write) begin
            r_peak_bin <= w_wk_bin_nxt;
            r_peak_mag <= w_wk_mag_nxt;
        end
    end

    assign peak_bin = r_peak_bin;
    assign peak_mag = r_peak_mag;

endmodule
`default_nettype wire

// File: doc/cart_to_polar.md
# cart_to_polar

Post-FFT reader stage. On a start pulse from `ffter`, it streams the real and imaginary FFT output buffers (`post_fft_buf_real` / `post_fft_buf_imag`) bin by bin. For each bin it computes the squared magnitude and writes it to the magnitude buffer. It also tracks the strongest bin and pulses `go_out` to the downstream pitch-detection logic when the frame is complete.

## Interface
- `N_BINS`, default 2048: bins processed per frame, addresses 0..N_BINS-1 (positive-frequency half of a 4096-point FFT); legal range 1..4096.
- `ADDR_W`, default 12: buffer address width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `go_in`  in  1  start request from `ffter`; sampled only in IDLE.
- `real_buf_addr`  out  ADDR_W  read address, real buffer.
- `real_buf_data`  in  16  signed real part.
- `imag_buf_addr`  out  ADDR_W  read address, imaginary buffer; always equals `real_buf_addr`.
- `imag_buf_data`  in  16  signed imaginary part.
- `mag_buf_addr`  out  ADDR_W  write address, magnitude buffer.
- `mag_buf_data`  out  32  unsigned squared magnitude.
- `mag_buf_wren`  out  1  write enable, magnitude buffer.
- `peak_bin`  out  ADDR_W  index of the largest magnitude in the last completed frame.
- `peak_mag`  out  32  magnitude at `peak_bin`.
- `busy`  out  1  high from the accepted start until `go_out`.
- `go_out`  out  1  one-cycle frame-done pulse.

## Operation
- States and transitions:
  - IDLE, on `go_in`=1 → READ.
  - READ, after address N_BINS-1 is issued → DRAIN.
  - DRAIN, after the last write → DONE.
  - DONE, always → IDLE, one cycle with `go_out`=1.
- READ: issue address i = 0,1,…,N_BINS-1, one per cycle, on both read ports.
- Both buffers have 1-cycle read latency: data for an address presented in cycle t is valid in cycle t+1.
- 3-stage datapath:
  - S1: capture re/im.
  - S2: register re·re and im·im as signed 16×16 products, 31 bits each, non-negative.
  - S3: register the 32-bit unsigned sum into `mag_buf_data`, with `mag_buf_addr`=i and `mag_buf_wren`=1.
- Width rule: the maximum is (−32768)²·2 = 0x8000_0000, so the result fits 32 bits unsigned. No saturation or overflow handling is needed.
- Peak tracking:
  - On start, clear the working peak to mag 0, bin 0.
  - On each S3 write, update only if mag > working peak (strict). Ties therefore keep the lowest bin.
  - `peak_bin`/`peak_mag` are copied from the working registers in DONE and hold until the next DONE.
  - If all magnitudes are 0, `peak_bin`=0 and `peak_mag`=0.
- `go_in` during READ/DRAIN/DONE is ignored; it is not queued.
- `go_in` held high continuously re-triggers a new frame from the IDLE cycle after DONE.
- Outside READ the read addresses hold 0. `mag_buf_wren`=0 except on valid S3 cycles.

## Timing
- Reset (async assert, any state) forces:
  - state IDLE;
  - all addresses 0, `mag_buf_data` 0;
  - `mag_buf_wren` 0, `go_out` 0, `busy` 0;
  - `peak_bin` 0, `peak_mag` 0;
  - pipeline valid bits cleared.
- Reset mid-frame: no further writes occur. Deassertion is synchronized to `clk` internally; the block resumes in IDLE.
- `go_in` sampled high at edge E (IDLE). The frame then runs as follows, with S = first cycle after E:
  - cycle S: `busy`=1 and `real_buf_addr`=0;
  - cycle S+i: address i presented;
  - cycle S+i+3: the write for bin i is visible (`mag_buf_wren`=1);
  - cycle S+N_BINS+2: last write;
  - cycle S+N_BINS+3: `go_out`=1 and `busy`=0, with `peak_*` already updated;
  - cycle S+N_BINS+4: IDLE.
- Latency from `go_in` to `go_out` is N_BINS+4 cycles. Writes are contiguous, with no bubbles.
- N_BINS=1: one address and one write; `go_out` at S+4.

## Test plan
- Impulse: bin 5 holds re=3, im=4, all other bins 0, N_BINS=16.
  - → `mag_buf_data`=25 at addr 5 and 0 elsewhere.
  - → exactly 16 writes at consecutive cycles S+3..S+18.
  - → `peak_bin`=5, `peak_mag`=25, `go_out` at S+19.
- Extremes: re=im=−32768 at bin 0 and re=32767, im=0 at bin 1.
  - → 0x8000_0000 and 0x3FFF_0001 written.
  - → `peak_bin`=0.
- Tie: bins 2 and 9 both hold magnitude 100, which is the maximum. → `peak_bin`=2, `peak_mag`=100.
- All-zero frame → 16 writes of 0, `peak_bin`=0, `peak_mag`=0.
- `go_in` pulsed at S+4 and at the DONE cycle.
  - → both pulses ignored; exactly one frame runs and `go_out` pulses once.
  - → a subsequent `go_in` in IDLE starts a new frame whose peak values replace the previous ones.
- `reset_n` asserted at S+7.
  - → `mag_buf_wren`, `go_out`, `busy`, `peak_*` and all addresses read 0 immediately.
  - → no writes after reset.
  - → after release, a new `go_in` produces a full, correct frame.
